// File: rtl/rv64_pkg.sv
// ----------------------------------------------------------------------------
// rv64_pkg
// Shared RV64 front-end definitions: machine widths, the default reset fetch
// address and the fetch FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package rv64_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // REQ   : request presented to imem, waiting for ready
    // WAIT  : one request outstanding, waiting for its response
    // HOLD  : response captured while decode was stalled
    // DRAIN : response of a flushed request still to come; it is dropped
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage : rv64_pkg

// File: rtl/perf_counter.sv
// ----------------------------------------------------------------------------
// perf_counter
// Free-running XLEN-bit event counter, wraps at 2^XLEN.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-high reset, clears the count
//   i_en    - count enable, one increment per cycle while high
//   o_count - current count
// ----------------------------------------------------------------------------
module perf_counter
    import rv64_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    output logic [XLEN-1:0] o_count
);

    logic [XLEN-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule : perf_counter

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// RV64 instruction fetch: drives a single-outstanding instruction-memory
// request/response interface and loads the IF/ID register feeding decode.
// Handles decode stalls (response parked in a hold register) and branch
// flushes (redirect of pc_q, in-flight response drained).
//
// Parameters:
//   RESET_PC        - first fetch address after reset
// Ports:
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   stall_if        - decode hazard stall, IF/ID holds while high
//   flush_id        - taken branch/jump: bubble IF/ID, redirect to redirect_pc
//   redirect_pc     - redirect target, used only with flush_id
//   imem_req_*      - request handshake (valid/addr out, ready in)
//   imem_rsp_*      - in-order read response, not held by memory
//   id_valid/pc/instr - IF/ID register
//   perf_fetched, perf_stall - performance counters
//
// Build option: define FETCH_PERF_CNT_EN to instantiate the performance
// counters; otherwise both counter outputs are constant zero.
// ----------------------------------------------------------------------------
module fetch_stage
    import rv64_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    input  logic            flush_id,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_hold_instr;
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [ILEN-1:0] r_id_instr;

    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [ILEN-1:0] w_hold_nxt;
    logic            w_id_valid_nxt;
    logic [XLEN-1:0] w_id_pc_nxt;
    logic [ILEN-1:0] w_id_instr_nxt;
    logic            w_req_fire;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_hold_instr <= '0;
            r_id_valid   <= 1'b0;
            r_id_pc      <= '0;
            r_id_instr   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_nxt;
            r_id_valid   <= w_id_valid_nxt;
            r_id_pc      <= w_id_pc_nxt;
            r_id_instr   <= w_id_instr_nxt;
        end
    end

    assign w_req_fire = (r_state == ST_REQ) && imem_req_ready;

    // Next-state and IF/ID update
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_hold_nxt     = r_hold_instr;
        w_id_valid_nxt = r_id_valid;
        w_id_pc_nxt    = r_id_pc;
        w_id_instr_nxt = r_id_instr;

        if (flush_id) begin
            // Flush beats stall. Only a request that is actually in flight
            // after this edge needs draining; a response landing in the
            // same cycle has already retired it.
            w_pc_nxt       = redirect_pc;
            w_id_valid_nxt = 1'b0;
            unique case (r_state)
                ST_REQ:   w_state_nxt = w_req_fire ? ST_DRAIN : ST_REQ;
                ST_WAIT:  w_state_nxt = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                ST_HOLD:  w_state_nxt = ST_REQ;
                ST_DRAIN: w_state_nxt = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                default:  w_state_nxt = ST_REQ;
            endcase
        end else begin
            // Bubble unless an instruction is delivered below.
            if (!stall_if) begin
                w_id_valid_nxt = 1'b0;
            end
            unique case (r_state)
                ST_REQ: begin
                    if (w_req_fire) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (stall_if) begin
                            // Memory does not hold the response; park it.
                            w_hold_nxt  = imem_rsp_data;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_id_valid_nxt = 1'b1;
                            w_id_pc_nxt    = r_pc;
                            w_id_instr_nxt = imem_rsp_data;
                            w_pc_nxt       = r_pc + 64'd4;
                            w_state_nxt    = ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_if) begin
                        w_id_valid_nxt = 1'b1;
                        w_id_pc_nxt    = r_pc;
                        w_id_instr_nxt = r_hold_instr;
                        w_pc_nxt       = r_pc + 64'd4;
                        w_state_nxt    = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                default: w_state_nxt = ST_REQ;
            endcase
        end
    end

    // The address is pc_q, which only changes on delivery or flush, so it is
    // stable for the whole time the request waits for ready.
    assign imem_req_valid = (r_state == ST_REQ) && !rst;
    assign imem_req_addr  = r_pc;

    assign id_valid = r_id_valid;
    assign id_pc    = r_id_pc;
    assign id_instr = r_id_instr;

`ifdef FETCH_PERF_CNT_EN
    // Outside stall/flush, IF/ID is valid next cycle only on a delivery.
    logic w_fetch_en;
    assign w_fetch_en = !stall_if && !flush_id && w_id_valid_nxt;

    perf_counter u_perf_fetched (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (w_fetch_en),
        .o_count (perf_fetched)
    );

    perf_counter u_perf_stall (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (stall_if),
        .o_count (perf_stall)
    );
`else
    assign perf_fetched = '0;
    assign perf_stall   = '0;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The bench plays the instruction memory by
// hand, one clock step at a time, and checks outputs 1 time unit after each
// rising edge against hand-derived values.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        flush_id;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall;

    int          n_pass;
    int          n_total;
    logic [63:0] exp_fetched;
    logic [63:0] exp_stall;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_if       (stall_if),
        .flush_id       (flush_id),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_perf(input string tag);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fetched"}, perf_fetched, exp_fetched);
        chk({tag, "_stall"}, perf_stall, exp_stall);
`else
        chk({tag, "_fetched"}, perf_fetched, 64'd0);
        chk({tag, "_stall"}, perf_stall, 64'd0);
`endif
    endtask

    // One clock: account the stall counter for this cycle, then advance.
    task automatic step();
        if (rst) begin
            exp_fetched = 64'd0;
            exp_stall   = 64'd0;
        end else if (stall_if) begin
            exp_stall = exp_stall + 64'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        exp_fetched = 64'd0;
        exp_stall = 64'd0;
        rst = 1'b1;
        stall_if = 1'b0;
        flush_id = 1'b0;
        redirect_pc = 64'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0;

        // Reset state
        step();
        step();
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);
        chk("rst_id_instr", {32'd0, id_instr}, 64'd0);
        chk_perf("rst_perf");

        rst = 1'b0;
        #1;
        chk("boot_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("boot_req_addr", imem_req_addr, 64'h8000_0000);

        // Sequential fetch, 1-cycle response latency
        imem_req_ready = 1'b1;
        step();                                   // REQ -> WAIT
        chk("wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0000_0013;
        step();                                   // deliver 0x80000000
        exp_fetched = exp_fetched + 64'd1;
        chk("f0_id_valid", {63'd0, id_valid}, 64'd1);
        chk("f0_id_pc", id_pc, 64'h8000_0000);
        chk("f0_id_instr", {32'd0, id_instr}, 64'h13);
        chk("f0_next_addr", imem_req_addr, 64'h8000_0004);
        imem_rsp_valid = 1'b0;
        step();                                   // REQ -> WAIT, bubble
        chk("f1_bubble", {63'd0, id_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0020_0113;
        step();                                   // deliver 0x80000004
        exp_fetched = exp_fetched + 64'd1;
        imem_rsp_valid = 1'b0;
        chk("f1_id_pc", id_pc, 64'h8000_0004);
        chk("f1_id_instr", {32'd0, id_instr}, 64'h0020_0113);
        chk("f1_next_addr", imem_req_addr, 64'h8000_0008);

        // Stall for 3 cycles while the response arrives
        stall_if = 1'b1;
        step();                                   // REQ -> WAIT, IF/ID held
        chk("st0_id_valid", {63'd0, id_valid}, 64'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0050_0093;
        step();                                   // WAIT -> HOLD
        imem_rsp_valid = 1'b0;
        chk("st1_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("st1_id_instr", {32'd0, id_instr}, 64'h0020_0113);
        step();                                   // still HOLD
        chk("st2_id_valid", {63'd0, id_valid}, 64'd1);
        chk("st2_id_pc", id_pc, 64'h8000_0004);
        chk("st2_id_instr", {32'd0, id_instr}, 64'h0020_0113);
        chk("st2_req_valid", {63'd0, imem_req_valid}, 64'd0);
        stall_if = 1'b0;
        step();                                   // HOLD -> IF/ID
        exp_fetched = exp_fetched + 64'd1;
        chk("st3_id_valid", {63'd0, id_valid}, 64'd1);
        chk("st3_id_pc", id_pc, 64'h8000_0008);
        chk("st3_id_instr", {32'd0, id_instr}, 64'h0050_0093);
        chk("st3_next_addr", imem_req_addr, 64'h8000_000C);

        // Flush while WAIT: next response dropped
        step();                                   // REQ -> WAIT
        flush_id = 1'b1;
        redirect_pc = 64'h8000_0100;
        step();                                   // WAIT -> DRAIN
        flush_id = 1'b0;
        chk("fw_id_valid", {63'd0, id_valid}, 64'd0);
        chk("fw_drain_req", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        step();                                   // stale response dropped
        imem_rsp_valid = 1'b0;
        chk("fw_drop_valid", {63'd0, id_valid}, 64'd0);
        chk("fw_drop_instr", {32'd0, id_instr}, 64'h0050_0093);
        chk("fw_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("fw_req_addr", imem_req_addr, 64'h8000_0100);

        // Ready low for 5 cycles: address stable
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rdy_req_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("rdy_req_addr", imem_req_addr, 64'h8000_0100);
        end
        imem_req_ready = 1'b1;
        step();                                   // REQ -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0010_0113;
        step();                                   // deliver 0x80000100
        exp_fetched = exp_fetched + 64'd1;
        imem_rsp_valid = 1'b0;
        chk("rd_id_pc", id_pc, 64'h8000_0100);
        chk("rd_id_instr", {32'd0, id_instr}, 64'h0010_0113);

        // Flush and stall together, with a handshake in the same cycle
        flush_id = 1'b1;
        stall_if = 1'b1;
        redirect_pc = 64'h8000_0200;
        step();                                   // REQ fire + flush -> DRAIN
        flush_id = 1'b0;
        stall_if = 1'b0;
        chk("fs_id_valid", {63'd0, id_valid}, 64'd0);
        chk("fs_drain_req", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        step();                                   // DRAIN -> REQ
        imem_rsp_valid = 1'b0;
        chk("fs_req_addr", imem_req_addr, 64'h8000_0200);
        chk("fs_req_valid", {63'd0, imem_req_valid}, 64'd1);

        // Response and flush in the same WAIT cycle -> straight to REQ
        step();                                   // REQ -> WAIT
        imem_rsp_valid = 1'b1;
        flush_id = 1'b1;
        redirect_pc = 64'h8000_0300;
        step();
        imem_rsp_valid = 1'b0;
        flush_id = 1'b0;
        chk("rf_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("rf_req_addr", imem_req_addr, 64'h8000_0300);
        chk("rf_id_valid", {63'd0, id_valid}, 64'd0);

        // Flush while HOLD discards the held instruction
        step();                                   // REQ -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0000_AAAA;
        stall_if = 1'b1;
        step();                                   // WAIT -> HOLD
        imem_rsp_valid = 1'b0;
        flush_id = 1'b1;
        redirect_pc = 64'h8000_0400;
        step();                                   // HOLD -> REQ
        flush_id = 1'b0;
        stall_if = 1'b0;
        chk("hf_req_addr", imem_req_addr, 64'h8000_0400);
        chk("hf_req_valid", {63'd0, imem_req_valid}, 64'd1);
        imem_req_ready = 1'b0;
        step();
        chk("hf_no_held_valid", {63'd0, id_valid}, 64'd0);
        chk("hf_no_held_instr", {32'd0, id_instr}, 64'h0010_0113);
        imem_req_ready = 1'b1;

        // Second flush while draining updates only pc_q
        step();                                   // REQ -> WAIT
        flush_id = 1'b1;
        redirect_pc = 64'h8000_0500;
        step();                                   // WAIT -> DRAIN
        redirect_pc = 64'h8000_0600;
        step();                                   // DRAIN, pc_q updated
        flush_id = 1'b0;
        chk("df_drain_req", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        step();                                   // DRAIN -> REQ
        imem_rsp_valid = 1'b0;
        chk("df_req_addr", imem_req_addr, 64'h8000_0600);
        chk("df_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk_perf("mid_perf");

        // Reset in the middle of an outstanding request
        step();                                   // REQ -> WAIT
        rst = 1'b1;
        step();
        chk("mr_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("mr_id_valid", {63'd0, id_valid}, 64'd0);
        chk("mr_id_pc", id_pc, 64'd0);
        chk("mr_id_instr", {32'd0, id_instr}, 64'd0);
        chk_perf("mr_perf");
        rst = 1'b0;
        #1;
        chk("mr_req_valid_after", {63'd0, imem_req_valid}, 64'd1);
        chk("mr_req_addr_after", imem_req_addr, 64'h8000_0000);
        step();                                   // REQ -> WAIT
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0000_0013;
        step();
        exp_fetched = exp_fetched + 64'd1;
        imem_rsp_valid = 1'b0;
        chk("mr_id_pc_fetch", id_pc, 64'h8000_0000);
        chk("mr_next_addr", imem_req_addr, 64'h8000_0004);
        chk_perf("end_perf");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fetch_stage
